// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode, funct and exception constants for riscv_alu
//
// Purpose: decode constants used by the riscv_alu execute unit and its tests.
// Ports: none (package).

package alu_pkg;

  // Major opcodes handled by the execute unit
  localparam logic [6:0] OPCODE_ALU     = 7'b0110011;
  localparam logic [6:0] OPCODE_ALU_IMM = 7'b0010011;
  localparam logic [6:0] OPCODE_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPCODE_JUMP    = 7'b1101111;

  // funct7 variants
  localparam logic [6:0] ADD_OR_AND_FUNCT7 = 7'b0000000;
  localparam logic [6:0] SUB_FUNCT7        = 7'b0100000;
  localparam logic [6:0] MUL_FUNCT7        = 7'b0000001;

  // funct3 codes
  localparam logic [2:0] ADD_FUNCT3  = 3'b000;
  localparam logic [2:0] ADDI_FUNCT3 = 3'b000;
  localparam logic [2:0] SUB_FUNCT3  = 3'b000;
  localparam logic [2:0] MUL_FUNCT3  = 3'b000;
  localparam logic [2:0] SLL_FUNCT3  = 3'b001;
  localparam logic [2:0] SLT_FUNCT3  = 3'b010;
  localparam logic [2:0] SLTU_FUNCT3 = 3'b011;
  localparam logic [2:0] XOR_FUNCT3  = 3'b100;
  localparam logic [2:0] SR_FUNCT3   = 3'b101;
  localparam logic [2:0] OR_FUNCT3   = 3'b110;
  localparam logic [2:0] AND_FUNCT3  = 3'b111;

  // Exception codes
  localparam logic [31:0] EXC_NONE       = 32'd0;
  localparam logic [31:0] EXC_BAD_OPCODE = 32'd1;
  localparam logic [31:0] EXC_BAD_FUNCT  = 32'd2;

endpackage

// File: rtl/riscv_alu_mul.sv
// rtl/riscv_alu_mul.sv - combinational low-half multiplier for riscv_alu
//
// Purpose: produces the low INSTR_SIZE bits of a*b (signedness is irrelevant
//          for the low half). Only exists when RISCV_ALU_MUL_EN is defined.
// Ports:
//   a, b     in  INSTR_SIZE  operands
//   product  out INSTR_SIZE  low half of a*b

`ifdef RISCV_ALU_MUL_EN
module riscv_alu_mul #(
  parameter int INSTR_SIZE = 32
) (
  input  logic [INSTR_SIZE-1:0] a,
  input  logic [INSTR_SIZE-1:0] b,
  output logic [INSTR_SIZE-1:0] product
);

  // Same-width operands and result keep only the low half of the product
  assign product = a * b;

endmodule
`endif

// File: rtl/riscv_alu.sv
// rtl/riscv_alu.sv - RV32I/M single-cycle execute unit with registered outputs
//
// Purpose: decodes opcode/funct7/funct3, computes ALU, branch and jump results,
//          flags unsupported encodings, and registers everything (1-cycle latency).
// Optional: RISCV_ALU_MUL_EN enables MUL via riscv_alu_mul; otherwise MUL is illegal.
// Ports:
//   clk            in   rising-edge clock
//   reset          in   asynchronous active-high reset
//   in_valid       in   decode fields/operands valid
//   opcode         in   [6:0] major opcode
//   funct7         in   [6:0] funct7 field
//   funct3         in   [2:0] funct3 field
//   aluIn1         in   operand A (rs1 or PC)
//   aluIn2         in   operand B (rs2, immediate or offset)
//   out_valid      out  registered in_valid
//   aluOut         out  registered result
//   zero           out  registered branch-equality flag
//   exceptionCode  out  registered exception code, 0 = none

module riscv_alu
  import alu_pkg::*;
#(
  parameter int INSTR_SIZE = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [6:0]            opcode,
  input  logic [6:0]            funct7,
  input  logic [2:0]            funct3,
  input  logic [INSTR_SIZE-1:0] aluIn1,
  input  logic [INSTR_SIZE-1:0] aluIn2,
  output logic                  out_valid,
  output logic [INSTR_SIZE-1:0] aluOut,
  output logic                  zero,
  output logic [INSTR_SIZE-1:0] exceptionCode
);

  logic [4:0]            shamt;
  logic [INSTR_SIZE-1:0] sum;
  logic [INSTR_SIZE-1:0] diff;
  logic [INSTR_SIZE-1:0] sra_res;
  logic [INSTR_SIZE-1:0] base_res;
  logic [INSTR_SIZE-1:0] res_d;
  logic [INSTR_SIZE-1:0] exc_d;
  logic                  zero_d;
  logic                  slt;
  logic                  sltu;

  assign shamt   = aluIn2[4:0];
  assign sum     = aluIn1 + aluIn2;
  assign diff    = aluIn1 - aluIn2;
  assign sra_res = INSTR_SIZE'($signed(aluIn1) >>> shamt);
  assign slt     = $signed(aluIn1) < $signed(aluIn2);
  assign sltu    = aluIn1 < aluIn2;

`ifdef RISCV_ALU_MUL_EN
  logic [INSTR_SIZE-1:0] mul_res;

  riscv_alu_mul #(
    .INSTR_SIZE(INSTR_SIZE)
  ) u_mul (
    .a       (aluIn1),
    .b       (aluIn2),
    .product (mul_res)
  );
`endif

  // Operation selected by funct3 alone; shared by register and immediate forms
  always_comb begin
    base_res = '0;
    case (funct3)
      ADD_FUNCT3:  base_res = sum;
      SLL_FUNCT3:  base_res = aluIn1 << shamt;
      SLT_FUNCT3:  base_res = {{(INSTR_SIZE-1){1'b0}}, slt};
      SLTU_FUNCT3: base_res = {{(INSTR_SIZE-1){1'b0}}, sltu};
      XOR_FUNCT3:  base_res = aluIn1 ^ aluIn2;
      SR_FUNCT3:   base_res = aluIn1 >> shamt;
      OR_FUNCT3:   base_res = aluIn1 | aluIn2;
      AND_FUNCT3:  base_res = aluIn1 & aluIn2;
      default:     base_res = '0;
    endcase
  end

  // Decode; any exception forces result and zero flag to 0
  always_comb begin
    res_d  = '0;
    zero_d = 1'b0;
    exc_d  = INSTR_SIZE'(EXC_NONE);
    case (opcode)
      OPCODE_ALU: begin
        if (funct7 == ADD_OR_AND_FUNCT7) begin
          res_d = base_res;
        end else if (funct7 == SUB_FUNCT7 && funct3 == SUB_FUNCT3) begin
          res_d = diff;
        end else if (funct7 == SUB_FUNCT7 && funct3 == SR_FUNCT3) begin
          res_d = sra_res;
        end else if (funct7 == MUL_FUNCT7 && funct3 == MUL_FUNCT3) begin
`ifdef RISCV_ALU_MUL_EN
          res_d = mul_res;
`else
          exc_d = INSTR_SIZE'(EXC_BAD_FUNCT);
`endif
        end else begin
          exc_d = INSTR_SIZE'(EXC_BAD_FUNCT);
        end
      end
      OPCODE_ALU_IMM: begin
        // funct7 only qualifies the shift-immediate forms
        if (funct3 == SR_FUNCT3 && funct7 == SUB_FUNCT7) begin
          res_d = sra_res;
        end else if ((funct3 == SLL_FUNCT3 || funct3 == SR_FUNCT3) &&
                     funct7 != ADD_OR_AND_FUNCT7) begin
          exc_d = INSTR_SIZE'(EXC_BAD_FUNCT);
        end else begin
          res_d = base_res;
        end
      end
      OPCODE_BRANCH: begin
        res_d  = sum;
        zero_d = (aluIn1 == aluIn2);
      end
      OPCODE_JUMP: begin
        res_d = sum;
      end
      default: begin
        exc_d = INSTR_SIZE'(EXC_BAD_OPCODE);
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid     <= 1'b0;
      aluOut        <= '0;
      zero          <= 1'b0;
      exceptionCode <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        aluOut        <= res_d;
        zero          <= zero_d;
        exceptionCode <= exc_d;
      end
    end
  end

endmodule

// File: tb/tb_riscv_alu.sv
// tb/tb_riscv_alu.sv - directed self-checking bench for riscv_alu

module tb_riscv_alu;
  import alu_pkg::*;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [6:0]  opcode;
  logic [6:0]  funct7;
  logic [2:0]  funct3;
  logic [31:0] aluIn1;
  logic [31:0] aluIn2;
  logic        out_valid;
  logic [31:0] aluOut;
  logic        zero;
  logic [31:0] exceptionCode;

  int errors = 0;
  int checks = 0;

  riscv_alu #(.INSTR_SIZE(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .opcode        (opcode),
    .funct7        (funct7),
    .funct3        (funct3),
    .aluIn1        (aluIn1),
    .aluIn2        (aluIn2),
    .out_valid     (out_valid),
    .aluOut        (aluOut),
    .zero          (zero),
    .exceptionCode (exceptionCode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one operation at the falling edge, then sample 1ns after the capturing edge
  task automatic op(input logic v, input logic [6:0] opc, input logic [6:0] f7,
                    input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    in_valid = v;
    opcode   = opc;
    funct7   = f7;
    funct3   = f3;
    aluIn1   = a;
    aluIn2   = b;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [31:0] res,
                            input logic z, input logic [31:0] exc);
    chk({tag, ".valid"}, {31'b0, out_valid}, 32'd1);
    chk({tag, ".out"}, aluOut, res);
    chk({tag, ".zero"}, {31'b0, zero}, {31'b0, z});
    chk({tag, ".exc"}, exceptionCode, exc);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; opcode = '0; funct7 = '0; funct3 = '0;
    aluIn1 = '0; aluIn2 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.valid", {31'b0, out_valid}, 32'd0);
    chk("rst.out", aluOut, 32'd0);
    chk("rst.exc", exceptionCode, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    op(1'b1, OPCODE_ALU, 7'b0000000, 3'b000, 32'd23, 32'd7);
    expect_out("add", 32'd30, 1'b0, 32'd0);

    // Async reset mid-cycle with a live operation: outputs clear without an edge
    @(negedge clk);
    in_valid = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    chk("arst.valid", {31'b0, out_valid}, 32'd0);
    chk("arst.out", aluOut, 32'd0);
    chk("arst.zero", {31'b0, zero}, 32'd0);
    chk("arst.exc", exceptionCode, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    op(1'b1, OPCODE_ALU, 7'b0100000, 3'b000, 32'd4, 32'd2);
    expect_out("sub", 32'd2, 1'b0, 32'd0);
    op(1'b1, OPCODE_ALU, 7'b0100000, 3'b000, 32'd0, 32'd1);
    expect_out("sub.wrap", 32'hFFFF_FFFF, 1'b0, 32'd0);
    op(1'b1, OPCODE_ALU, 7'b0000000, 3'b110, 32'b001011, 32'b010010);
    expect_out("or", 32'b011011, 1'b0, 32'd0);
    op(1'b1, OPCODE_ALU, 7'b0000000, 3'b111, 32'b010010, 32'b001110);
    expect_out("and", 32'b000010, 1'b0, 32'd0);
    op(1'b1, OPCODE_ALU, 7'b0000000, 3'b100, 32'h0000_F0F0, 32'h0000_FF00);
    expect_out("xor", 32'h0000_0FF0, 1'b0, 32'd0);
    op(1'b1, OPCODE_ALU, 7'b0000000, 3'b001, 32'd1, 32'h0000_0025);
    expect_out("sll.shamt", 32'd32, 1'b0, 32'd0);
    op(1'b1, OPCODE_ALU, 7'b0000000, 3'b010, 32'hFFFF_FFFF, 32'd1);
    expect_out("slt", 32'd1, 1'b0, 32'd0);
    op(1'b1, OPCODE_ALU, 7'b0000000, 3'b011, 32'hFFFF_FFFF, 32'd1);
    expect_out("sltu", 32'd0, 1'b0, 32'd0);
    op(1'b1, OPCODE_ALU, 7'b0000000, 3'b101, 32'h8000_0000, 32'd31);
    expect_out("srl", 32'd1, 1'b0, 32'd0);
    op(1'b1, OPCODE_ALU, 7'b0100000, 3'b101, 32'h8000_0000, 32'd31);
    expect_out("sra", 32'hFFFF_FFFF, 1'b0, 32'd0);

    op(1'b1, OPCODE_ALU_IMM, 7'b0000000, 3'b000, 32'd7, 32'd3);
    expect_out("addi", 32'd10, 1'b0, 32'd0);
    op(1'b1, OPCODE_ALU_IMM, 7'b0100000, 3'b000, 32'd7, 32'd3);
    expect_out("addi.f7", 32'd10, 1'b0, 32'd0);
    op(1'b1, OPCODE_ALU_IMM, 7'b0100000, 3'b101, 32'hFFFF_FF00, 32'd4);
    expect_out("srai", 32'hFFFF_FFF0, 1'b0, 32'd0);
    op(1'b1, OPCODE_ALU_IMM, 7'b0100000, 3'b001, 32'd5, 32'd1);
    expect_out("slli.bad", 32'd0, 1'b0, 32'd2);

    op(1'b1, OPCODE_BRANCH, 7'b0000000, 3'b000, 32'd2, 32'd10);
    expect_out("br.ne", 32'd12, 1'b0, 32'd0);
    op(1'b1, OPCODE_BRANCH, 7'b1111111, 3'b111, 32'd18, 32'd18);
    expect_out("br.eq", 32'd36, 1'b1, 32'd0);
    op(1'b1, OPCODE_JUMP, 7'b0000000, 3'b000, 32'd18, 32'd0);
    expect_out("jal", 32'd18, 1'b0, 32'd0);

    op(1'b1, 7'b1100001, 7'b0000000, 3'b000, 32'd10, 32'd9);
    expect_out("bad.opc", 32'd0, 1'b0, 32'd1);
    op(1'b1, OPCODE_ALU, 7'b0100000, 3'b110, 32'd10, 32'd9);
    expect_out("bad.f3", 32'd0, 1'b0, 32'd2);
    op(1'b1, OPCODE_ALU, 7'b0000010, 3'b000, 32'd10, 32'd9);
    expect_out("bad.f7", 32'd0, 1'b0, 32'd2);

    // in_valid low: out_valid drops, payload holds the last accepted result
    op(1'b1, OPCODE_BRANCH, 7'b0000000, 3'b000, 32'd5, 32'd5);
    op(1'b0, OPCODE_ALU, 7'b0000000, 3'b000, 32'd100, 32'd1);
    chk("hold.valid", {31'b0, out_valid}, 32'd0);
    chk("hold.out", aluOut, 32'd10);
    chk("hold.zero", {31'b0, zero}, 32'd1);
    chk("hold.exc", exceptionCode, 32'd0);

`ifdef RISCV_ALU_MUL_EN
    op(1'b1, OPCODE_ALU, 7'b0000001, 3'b000, 32'd42, 32'd3);
    expect_out("mul", 32'd126, 1'b0, 32'd0);
    op(1'b1, OPCODE_ALU, 7'b0000001, 3'b000, 32'h0001_0001, 32'h0001_0001);
    expect_out("mul.wrap", 32'h0002_0001, 1'b0, 32'd0);
`else
    op(1'b1, OPCODE_ALU, 7'b0000001, 3'b000, 32'd42, 32'd3);
    expect_out("mul.off", 32'd0, 1'b0, 32'd2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/riscv_alu.md
Name: riscv_alu

Overview:
- Single-cycle-issue RV32I/M integer execute unit for the in-order pipeline's EX stage.
- Decodes opcode/funct7/funct3 and computes one of the following:
  - an arithmetic/logic result
  - a branch target sum plus an equality flag
  - a jump target sum
- Raises an exception code for unsupported encodings.
- All outputs are registered, with 1-cycle latency.

Parameters:
- INSTR_SIZE, 32, width of operands, result and exceptionCode.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands/decode fields valid this cycle.
- opcode  in  7  RISC-V major opcode.
- funct7  in  7  RISC-V funct7 field.
- funct3  in  3  RISC-V funct3 field.
- aluIn1  in  INSTR_SIZE  operand A (rs1 or PC).
- aluIn2  in  INSTR_SIZE  operand B (rs2, immediate or offset).
- out_valid  out  1  registered result valid.
- aluOut  out  INSTR_SIZE  registered result.
- zero  out  1  registered branch-equality flag.
- exceptionCode  out  INSTR_SIZE  registered exception code; 0 means none.

Behaviour:
- Reset (asynchronous, active-high): out_valid, aluOut, zero and exceptionCode all go to 0 immediately and are held while reset is high.
- Every rising clk edge, the outputs capture the combinational result of the current inputs.
  - out_valid <= in_valid.
  - When in_valid=0, all other outputs hold their previous values.
- Latency is 1 cycle. There is no backpressure, and a new operation may be accepted every cycle.
- OPCODE_ALU (0110011):
  - funct7=0000000: funct3 selects the operation.
    - 000 ADD
    - 001 SLL (shift by aluIn2[4:0])
    - 010 SLT (signed)
    - 011 SLTU
    - 100 XOR
    - 101 SRL
    - 110 OR
    - 111 AND
  - funct7=0100000: funct3 000 is SUB (A-B); funct3 101 is SRA. Any other funct3 is illegal.
  - funct7=0000001, funct3=000: MUL, result is the low 32 bits of A*B. Requires MUL_EN.
  - Any other funct7 value is illegal.
- OPCODE_ALU_IMM (0010011):
  - funct3 uses the same mapping as OPCODE_ALU with funct7=0000000 (ADDI=000, etc.).
  - funct3 101 with funct7=0100000 is SRAI.
  - funct3 001/101 with any other funct7 is illegal.
- OPCODE_BRANCH (1100011): aluOut=A+B; zero=(A==B). funct fields are ignored.
- OPCODE_JUMP (1101111): aluOut=A+B. funct fields are ignored.
- zero is 0 for every non-branch opcode.
- Arithmetic wraps modulo 2^32, and no overflow is flagged.
- Unknown opcode: exceptionCode=1, aluOut=0, zero=0.
- Known opcode with illegal funct combination: exceptionCode=2, aluOut=0, zero=0.
- Legal operation: exceptionCode=0.

Optional Feature:
- Macro: RISCV_ALU_MUL_EN.
- Defined: MUL (funct7=0000001, funct3=000) is supported and produces the low 32 bits of the product.
- Undefined: the same encoding raises exceptionCode=2 with aluOut=0, and no multiplier logic is synthesized.

Decomposition:
- Package alu_pkg holds the following constants:
  - OPCODE_ALU, OPCODE_ALU_IMM, OPCODE_BRANCH, OPCODE_JUMP
  - ADD_OR_AND_FUNCT7, SUB_FUNCT7, MUL_FUNCT7
  - ADD_FUNCT3, ADDI_FUNCT3, OR_FUNCT3, AND_FUNCT3, plus the remaining funct3 codes
  - EXC_NONE=0, EXC_BAD_OPCODE=1, EXC_BAD_FUNCT=2
- One sub-module, riscv_alu_mul: a combinational 32x32 low-product multiplier, instantiated only under RISCV_ALU_MUL_EN.

Test Plan:
- Reset behaviour: assert reset mid-operation with in_valid=1 and A=23, B=7 -> all outputs go to 0 at once, with no clock edge needed.
- ADD/SUB: OPCODE_ALU, funct7=0000000, funct3=000, A=23, B=7 -> next cycle aluOut=30, zero=0, exc=0.
  - Then funct7=0100000, A=4, B=2 -> aluOut=2.
- OR/AND/ADDI:
  - OR with A=0b001011, B=0b010010 -> aluOut=0b011011.
  - AND with A=0b010010, B=0b001110 -> aluOut=0b000010.
  - OPCODE_ALU_IMM, funct3=000, A=7, B=3 -> aluOut=10.
  - All three: exc=0.
- Branch/jump:
  - OPCODE_BRANCH, A=2, B=10 -> aluOut=12, zero=0.
  - OPCODE_BRANCH, A=18, B=18 -> aluOut=36, zero=1.
  - OPCODE_JUMP, A=18, B=0 -> aluOut=18, zero=0.
- Exceptions:
  - opcode=1100001, A=10, B=9 -> exc=1, zero=0, aluOut=0.
  - OPCODE_ALU with funct7=0100000, funct3=110 -> exc=2.
- MUL: A=42, B=3 -> aluOut=126, exc=0 with RISCV_ALU_MUL_EN defined; exc=2 without it.
